// File: rtl/motor_mixer.sv
// motor_mixer: quad-X mixer turning throttle and body rates into four clamped motor drives,
// one motor per cycle after each start rise, all outputs committed together.
module motor_mixer #(
  parameter int RATE_WIDTH       = 16,
  parameter int RATE_SHIFT       = 4,
  parameter int MOTOR_WIDTH      = 8,
  parameter int MOTOR_MIN        = 0,
  parameter int MOTOR_MAX        = 250,
  parameter int MIX_MIN_THROTTLE = 20
) (
  input  logic                   us_clk,
  input  logic                   resetn,
  input  logic                   start_signal,
  input  logic                   armed,
  input  logic [MOTOR_WIDTH-1:0] throttle,
  input  logic [RATE_WIDTH-1:0]  yaw_rate,
  input  logic [RATE_WIDTH-1:0]  roll_rate,
  input  logic [RATE_WIDTH-1:0]  pitch_rate,
  output logic [MOTOR_WIDTH-1:0] motor_fl,
  output logic [MOTOR_WIDTH-1:0] motor_fr,
  output logic [MOTOR_WIDTH-1:0] motor_rl,
  output logic [MOTOR_WIDTH-1:0] motor_rr,
  output logic                   active,
  output logic                   complete_signal
);
  localparam int ACC_W = 18;
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(MOTOR_MIN);
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(MOTOR_MAX);
  localparam logic [MOTOR_WIDTH-1:0] MIX_T = MOTOR_WIDTH'(MIX_MIN_THROTTLE);
  typedef enum logic [1:0] {IDLE, CALC, UPDATE} state_t;
  state_t state_q;
  logic start_prev_q, armed_q, complete_q, rise;
  logic [1:0] idx_q;
  logic [MOTOR_WIDTH-1:0] thr_q, res_d, fl_q, fr_q, rl_q, rr_q;
  logic [MOTOR_WIDTH-1:0] res_q [4];
  logic signed [RATE_WIDTH-1:0] yaw_q, roll_q, pitch_q;
  logic signed [ACC_W-1:0] y_t, r_t, p_t, thr_x, sum_d;
  assign rise  = start_signal & ~start_prev_q;
  assign y_t   = ACC_W'(yaw_q) >>> RATE_SHIFT;
  assign r_t   = ACC_W'(roll_q) >>> RATE_SHIFT;
  assign p_t   = ACC_W'(pitch_q) >>> RATE_SHIFT;
  assign thr_x = signed'(ACC_W'(thr_q));
  // idx order FL, FR, RL, RR: bit1 flips pitch, bit0 flips roll, equal bits flip yaw
  assign sum_d = thr_x + (idx_q[1] ? -p_t : p_t) + (idx_q[0] ? -r_t : r_t)
               + ((idx_q[1] ~^ idx_q[0]) ? -y_t : y_t);
  assign res_d = !armed_q ? '0 :
                 thr_q < MIX_T ? thr_q :
                 sum_d < LO ? MOTOR_WIDTH'(MOTOR_MIN) :
                 sum_d > HI ? MOTOR_WIDTH'(MOTOR_MAX) : sum_d[MOTOR_WIDTH-1:0];
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      complete_q   <= 1'b0;
      idx_q        <= '0;
      thr_q        <= '0;
      yaw_q        <= '0;
      roll_q       <= '0;
      pitch_q      <= '0;
      fl_q         <= '0;
      fr_q         <= '0;
      rl_q         <= '0;
      rr_q         <= '0;
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
    end else begin
      start_prev_q <= start_signal;
      complete_q   <= 1'b0;
      case (state_q)
        IDLE: if (rise) begin
          thr_q   <= throttle;
          yaw_q   <= yaw_rate;
          roll_q  <= roll_rate;
          pitch_q <= pitch_rate;
          armed_q <= armed;
          idx_q   <= '0;
          state_q <= CALC;
        end
        CALC: begin
          res_q[idx_q] <= res_d;
          idx_q        <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= UPDATE;
        end
        UPDATE: begin
          fl_q       <= res_q[0];
          fr_q       <= res_q[1];
          rl_q       <= res_q[2];
          rr_q       <= res_q[3];
          complete_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign motor_fl        = fl_q;
  assign motor_fr        = fr_q;
  assign motor_rl        = rl_q;
  assign motor_rr        = rr_q;
  assign active          = state_q != IDLE;
  assign complete_signal = complete_q;
endmodule

// File: tb/tb_motor_mixer.sv
// tb_motor_mixer: random and directed stimulus checked every cycle against a cycle-count
// reference model, plus literal expectations for the hand-worked mixing cases.
module tb_motor_mixer;
  logic us_clk = 0, resetn = 1, start_signal = 0, armed = 0;
  logic [7:0] throttle = 0;
  logic [15:0] yaw_rate = 0, roll_rate = 0, pitch_rate = 0;
  logic [7:0] motor_fl, motor_fr, motor_rl, motor_rr;
  logic active, complete_signal;
  int n_chk = 0, n_fail = 0;
  int na, nc;

  motor_mixer dut (
    .us_clk(us_clk), .resetn(resetn), .start_signal(start_signal), .armed(armed),
    .throttle(throttle), .yaw_rate(yaw_rate), .roll_rate(roll_rate), .pitch_rate(pitch_rate),
    .motor_fl(motor_fl), .motor_fr(motor_fr), .motor_rl(motor_rl), .motor_rr(motor_rr),
    .active(active), .complete_signal(complete_signal)
  );

  always #5 us_clk = ~us_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packed {FL, FR, RL, RR} straight from the mixing and override rules.
  function automatic logic [31:0] mix(input bit arm, input int t, input logic [15:0] y, r, p);
    int yi, ri, pi_, v;
    int s[4];
    logic [31:0] o;
    yi = int'($signed(y)) >>> 4;
    ri = int'($signed(r)) >>> 4;
    pi_ = int'($signed(p)) >>> 4;
    s[0] = t + pi_ + ri - yi;
    s[1] = t + pi_ - ri + yi;
    s[2] = t - pi_ + ri + yi;
    s[3] = t - pi_ - ri - yi;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      v = !arm ? 0 : (t < 20) ? t : (s[i] < 0) ? 0 : (s[i] > 250) ? 250 : s[i];
      o[31-8*i -: 8] = 8'(v);
    end
    return o;
  endfunction

  // Model: an accepted rise makes the run busy for five edges; the fifth edge commits.
  logic [31:0] exp_m = 0, pend = 0;
  bit exp_c = 0, prev = 0;
  int busy = 0;
  always @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      exp_m = 0; pend = 0; exp_c = 0; busy = 0; prev = 0;
    end else begin
      exp_c = 0;
      if (busy == 0) begin
        if (start_signal && !prev) begin
          pend = mix(armed, int'(throttle), yaw_rate, roll_rate, pitch_rate);
          busy = 5;
        end
      end else begin
        busy--;
        if (busy == 0) begin
          exp_m = pend;
          exp_c = 1;
        end
      end
      prev = start_signal;
    end
  end

  always @(negedge us_clk) begin
    chk("motor_fl", motor_fl, exp_m[31:24]);
    chk("motor_fr", motor_fr, exp_m[23:16]);
    chk("motor_rl", motor_rl, exp_m[15:8]);
    chk("motor_rr", motor_rr, exp_m[7:0]);
    chk("active", active, busy > 0);
    chk("complete", complete_signal, exp_c);
  end

  task automatic scramble();
    armed = 1'($urandom_range(0, 1));
    throttle = 8'($urandom);
    yaw_rate = 16'($urandom);
    roll_rate = 16'($urandom);
    pitch_rate = 16'($urandom);
  endtask

  task automatic run(input bit arm, input logic [7:0] t, input logic [15:0] y, r, p,
                     input int hold, input bit reinject, output int n_act, output int n_cmp);
    @(negedge us_clk);
    armed = arm; throttle = t; yaw_rate = y; roll_rate = r; pitch_rate = p;
    start_signal = 1;
    n_act = 0; n_cmp = 0;
    for (int i = 0; i < hold + 12; i++) begin
      @(negedge us_clk);
      n_act += int'(active);
      n_cmp += int'(complete_signal);
      if (i == 0) scramble();
      start_signal = (i + 1 < hold) || (reinject && i == 2);
    end
  endtask

  function automatic logic [31:0] motors();
    return {motor_fl, motor_fr, motor_rl, motor_rr};
  endfunction

  initial begin
    #1 resetn = 0;
    repeat (3) @(negedge us_clk);
    chk("reset_motors", motors(), 32'h0);
    chk("reset_active", active, 1'b0);
    chk("reset_complete", complete_signal, 1'b0);
    #1 resetn = 1;

    run(1, 100, 0, 0, 0, 1, 0, na, nc);
    chk("t1_motors", motors(), 32'h64646464);
    chk("t1_active_cycles", na, 5);
    chk("t1_complete_cycles", nc, 1);
    run(1, 100, 0, 16'hFF60, 16'h00A0, 1, 0, na, nc);
    chk("t2_motors", motors(), 32'h64785064);
    run(1, 240, 0, 0, 16'h0FA0, 1, 0, na, nc);
    chk("t3_motors", motors(), 32'hFAFA0000);
    run(1, 10, 16'h0640, 0, 0, 1, 0, na, nc);
    chk("t4_low_throttle", motors(), 32'h0A0A0A0A);
    run(1, 20, 16'h0640, 0, 0, 1, 0, na, nc);
    chk("t4_min_throttle", motors(), 32'h00787800);
    run(0, 20, 16'h0640, 0, 0, 1, 0, na, nc);
    chk("t4_disarmed", motors(), 32'h0);
    run(1, 150, 16'h0100, 0, 0, 20, 0, na, nc);
    chk("t5_held_motors", motors(), 32'h86A6A686);
    chk("t5_held_complete", nc, 1);
    run(1, 50, 0, 0, 0, 1, 1, na, nc);
    chk("t5_reinject_motors", motors(), 32'h32323232);
    chk("t5_reinject_complete", nc, 1);

    run(1, 100, 0, 0, 0, 1, 0, na, nc);
    chk("t6_before", motors(), 32'h64646464);
    @(negedge us_clk);
    armed = 1; throttle = 200; yaw_rate = 0; roll_rate = 0; pitch_rate = 0;
    start_signal = 1;
    @(negedge us_clk);
    start_signal = 0;
    @(negedge us_clk);
    #1 resetn = 0;
    #1;
    chk("t6_reset_motors", motors(), 32'h0);
    chk("t6_reset_complete", complete_signal, 1'b0);
    chk("t6_reset_active", active, 1'b0);
    @(negedge us_clk);
    #1 resetn = 1;
    run(1, 60, 0, 16'h0050, 0, 1, 0, na, nc);
    chk("t6_after", motors(), 32'h41374137);
    chk("t6_after_complete", nc, 1);

    for (int c = 0; c < 2000; c++) begin
      @(negedge us_clk);
      start_signal = ($urandom_range(0, 3) == 0);
      armed = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 2))
        0: throttle = 8'($urandom_range(0, 25));
        1: throttle = 8'($urandom_range(230, 255));
        default: throttle = 8'($urandom);
      endcase
      yaw_rate = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 1600)) - 800);
      roll_rate = 16'($urandom);
      pitch_rate = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4000));
      if ($urandom_range(0, 299) == 0) begin
        #1 resetn = 0;
        @(negedge us_clk);
        #1 resetn = 1;
      end
    end
    start_signal = 0;
    repeat (10) @(negedge us_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
